// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning channel mux.
// Holds the FSM state type and the dwell-limit helper used by the scan counter.
package mux_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic {
      MAN  = 1'b0,
      SCAN = 1'b1
   } mux_state_t;

   // A dwell of 0 behaves like 1: the counter limit never underflows.
   function automatic logic [7:0] dwell_limit(input logic [7:0] dwell);
      return (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
   endfunction

endpackage

// File: rtl/mux_scan_n_rr_next.sv
// Round-robin search: first valid channel strictly after cur, wrapping CH-1 -> 0.
// Purely combinational; found is low when no other channel is valid.
module rr_next #(
   parameter int CH   = 4,
   parameter int SELW = $clog2(CH)
) (
   input  logic [CH-1:0]   valid,
   input  logic [SELW-1:0] cur,
   output logic [SELW-1:0] nxt,
   output logic            found
);

   logic [SELW:0]   sum;
   logic [SELW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest valid channel wins.
   always_comb begin
      nxt   = cur;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = CH - 1; k >= 1; k--) begin
         sum = {1'b0, cur} + (SELW+1)'(k);
         if (sum >= (SELW+1)'(CH)) begin
            sum = sum - (SELW+1)'(CH);
         end
         idx = sum[SELW-1:0];
         if (valid[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel mux with manual select or dwell-based round-robin scan; 1-cycle registered output.
// Output register holds while out_valid && !out_ready; scan pointer and dwell counter freeze too.
module mux_scan_n
   import mux_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CH    = 4,
   parameter int SELW  = $clog2(CH)
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CH*WIDTH-1:0] in_data,
   input  logic [CH-1:0]       in_valid,
   input  logic [SELW-1:0]     sel,
   input  logic                mode,
   input  logic [7:0]          dwell,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SELW-1:0]     out_ch
);

   mux_state_t      state_q, state_d;
   logic [SELW-1:0] ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [SELW-1:0] sel_c;
   logic [SELW-1:0] cur;
   logic [7:0]      lim;
   logic            load;
   logic [SELW-1:0] rr_idx;
   logic            rr_found;
   logic [WIDTH-1:0] chan [CH];

   for (genvar k = 0; k < CH; k++) begin : g_chan
      assign chan[k] = in_data[k*WIDTH +: WIDTH];
   end

   // Out-of-range manual selections fall back to channel 0.
   assign sel_c = ({1'b0, sel} >= (SELW+1)'(CH)) ? '0 : sel;
   assign load  = !out_valid || out_ready;
   assign lim   = dwell_limit(dwell);

   rr_next #(
      .CH   (CH),
      .SELW (SELW)
   ) u_rr_next (
      .valid (in_valid),
      .cur   (ptr_q),
      .nxt   (rr_idx),
      .found (rr_found)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      cur     = sel_c;
      unique case (state_q)
         MAN: begin
            if (mode) begin
               state_d = SCAN;
               ptr_d   = sel_c;
               cnt_d   = '0;
            end
         end
         SCAN: begin
            if (!mode) begin
               state_d = MAN;
            end else begin
               cur = ptr_q;
               // A limit already exceeded (dwell lowered mid-run) advances at once.
               if (load) begin
                  if (cnt_q >= lim) begin
                     cnt_d = '0;
                     if (rr_found) begin
                        ptr_d = rr_idx;
                     end
                  end else if (in_valid[ptr_q]) begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
         end
         default: state_d = MAN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= MAN;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
      end else if (load) begin
         out_data  <= chan[cur];
         out_valid <= in_valid[cur];
         out_ch    <= cur;
      end
   end

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized bench for mux_scan_n against a cycle-level reference model.
module tb_mux_scan_n;
   import mux_pkg::*;

   localparam int CH = 4;
   localparam int W  = 16;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic [CH*W-1:0] in_data;
   logic [CH-1:0] in_valid;
   logic [1:0]    sel;
   logic          mode;
   logic [7:0]    dwell;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_ch;

   logic [3*W-1:0] in_data3;
   logic [2:0]    in_valid3;
   logic [1:0]    sel3;
   logic [W-1:0]  out_data3;
   logic          out_valid3;
   logic [1:0]    out_ch3;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit           m_scan;
   int           m_ptr;
   int           m_cnt;
   logic [W-1:0] m_data;
   logic         m_valid;
   int           m_ch;

   always #5 CLK = ~CLK;

   mux_scan_n #(.WIDTH(W), .CH(CH)) dut (
      .CLK(CLK), .RST_N(RST_N), .in_data(in_data), .in_valid(in_valid),
      .sel(sel), .mode(mode), .dwell(dwell), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
   );

   mux_scan_n #(.WIDTH(W), .CH(3), .SELW(2)) dut3 (
      .CLK(CLK), .RST_N(RST_N), .in_data(in_data3), .in_valid(in_valid3),
      .sel(sel3), .mode(1'b0), .dwell(8'd1), .out_data(out_data3),
      .out_valid(out_valid3), .out_ready(1'b1), .out_ch(out_ch3)
   );

   // One clock of behaviour, computed from the current inputs.
   task automatic model_step();
      int  cur;
      int  p;
      int  lim;
      bit  ld;
      if (!RST_N) begin
         m_scan = 0; m_ptr = 0; m_cnt = 0;
         m_data = '0; m_valid = 1'b0; m_ch = 0;
         return;
      end
      ld  = !m_valid || out_ready;
      lim = (dwell == 0) ? 0 : int'(dwell) - 1;
      cur = (int'(sel) >= CH) ? 0 : int'(sel);
      if (!m_scan) begin
         if (mode) begin
            m_scan = 1; m_ptr = cur; m_cnt = 0;
         end
      end else if (!mode) begin
         m_scan = 0;
      end else begin
         p   = m_ptr;
         cur = p;
         if (ld) begin
            if (m_cnt >= lim) begin
               m_cnt = 0;
               for (int k = 1; k < CH; k++) begin
                  if (in_valid[(p + k) % CH]) begin
                     m_ptr = (p + k) % CH;
                     break;
                  end
               end
            end else if (in_valid[cur]) begin
               m_cnt++;
            end
         end
      end
      if (ld) begin
         m_data  = in_data[cur*W +: W];
         m_valid = in_valid[cur];
         m_ch    = cur;
      end
   endtask

   task automatic step();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic rand_data();
      for (int k = 0; k < CH; k++) in_data[k*W +: W] = W'($urandom);
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; mode = 1'b0; sel = '0; dwell = 8'd1; out_ready = 1'b1;
      in_valid = '1; rand_data();
      in_data3 = '0; in_valid3 = '0; sel3 = '0;
      step();
      checks++;
      if (out_data !== '0 || out_valid !== 1'b0 || out_ch !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: got data=%h valid=%b ch=%0d, want 0/0/0", out_data, out_valid, out_ch);
      end
      checks++;
      if (dut.state_q !== MAN || dut.cnt_q !== 8'd0 || dut.ptr_q !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: got state=%0d cnt=%0d ptr=%0d, want MAN/0/0", dut.state_q, dut.cnt_q, dut.ptr_q);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_manual();
      apply_reset();
      mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1; rand_data();
      in_data[2*W +: W] = 16'hBEEF;
      step();
      checks++;
      if (out_data !== 16'hBEEF || out_ch !== 2'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL manual_beef: got data=%h ch=%0d valid=%b, want BEEF/2/1", out_data, out_ch, out_valid);
      end
      for (int i = 0; i < 30; i++) begin
         sel = 2'($urandom); in_valid = 4'($urandom); out_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         step();
         checks++;
         if (out_data !== m_data || out_valid !== m_valid || out_ch !== 2'(m_ch)) begin
            errors++;
            $display("FAIL manual_rand[%0d]: got %h/%b/%0d, want %h/%b/%0d", i, out_data, out_valid, out_ch, m_data, m_valid, m_ch);
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] d0;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 3; k++) in_data3[k*W +: W] = W'($urandom);
         in_valid3 = 3'b111;
         sel3 = (i % 2 == 0) ? 2'd3 : 2'(i % 3);
         d0 = in_data3[0 +: W];
         step();
         checks++;
         if (i % 2 == 0) begin
            if (out_ch3 !== 2'd0 || out_data3 !== d0) begin
               errors++;
               $display("FAIL out_of_range[%0d]: got ch=%0d data=%h, want ch=0 data=%h", i, out_ch3, out_data3, d0);
            end
         end else if (out_ch3 !== 2'(i % 3) || out_data3 !== in_data3[(i % 3)*W +: W]) begin
            errors++;
            $display("FAIL in_range3[%0d]: got ch=%0d data=%h, want ch=%0d", i, out_ch3, out_data3, i % 3);
         end
      end
   endtask

   task automatic test_scan_seq();
      int exp_ch [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      apply_reset();
      in_valid = 4'hF; out_ready = 1'b1; dwell = 8'd2; mode = 1'b0; sel = 2'd0;
      step();
      mode = 1'b1;
      step();
      for (int i = 0; i < 9; i++) begin
         rand_data();
         step();
         checks++;
         if (out_ch !== 2'(exp_ch[i]) || out_data !== m_data || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL scan_seq[%0d]: got ch=%0d data=%h, want ch=%0d data=%h", i, out_ch, out_data, exp_ch[i], m_data);
         end
      end
   endtask

   task automatic test_skip_wrap();
      int exp_ch [4] = '{1, 3, 1, 3};
      apply_reset();
      in_valid = 4'b1010; out_ready = 1'b1; dwell = 8'd1; mode = 1'b0; sel = 2'd1;
      step();
      mode = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         rand_data();
         step();
         checks++;
         if (out_ch !== 2'(exp_ch[i]) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL skip_wrap[%0d]: got ch=%0d, want %0d", i, out_ch, exp_ch[i]);
         end
      end
      in_valid = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_ch !== 2'd1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid[%0d]: got ch=%0d, want 1", i, out_ch);
         end
      end
   endtask

   task automatic test_stall();
      logic [W-1:0] h_data;
      int h_ch;
      int h_cnt;
      apply_reset();
      in_valid = 4'hF; out_ready = 1'b1; dwell = 8'd4; mode = 1'b0; sel = 2'd0;
      step();
      mode = 1'b1;
      step();
      step();
      step();
      h_data = m_data; h_ch = m_ch; h_cnt = m_cnt;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rand_data();
         step();
         checks++;
         if (out_data !== h_data || out_ch !== 2'(h_ch) || out_valid !== 1'b1 || dut.cnt_q !== 8'(h_cnt)) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got %h/%0d cnt=%0d, want %h/%0d cnt=%0d", i, out_data, out_ch, dut.cnt_q, h_data, h_ch, h_cnt);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_data();
         step();
         checks++;
         if (out_data !== m_data || out_ch !== 2'(m_ch) || out_valid !== m_valid) begin
            errors++;
            $display("FAIL stall_resume[%0d]: got %h/%0d, want %h/%0d", i, out_data, out_ch, m_data, m_ch);
         end
      end
   endtask

   task automatic test_reset_stall();
      apply_reset();
      in_valid = 4'hF; out_ready = 1'b1; dwell = 8'd3; mode = 1'b0; sel = 2'd1;
      step();
      mode = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      step();
      RST_N = 1'b0;
      step();
      checks++;
      if (out_data !== '0 || out_valid !== 1'b0 || out_ch !== 2'd0 || dut.state_q !== MAN) begin
         errors++;
         $display("FAIL reset_stall: got %h/%b/%0d state=%0d, want 0/0/0 MAN", out_data, out_valid, out_ch, dut.state_q);
      end
      RST_N = 1'b1; mode = 1'b0; in_valid = '0;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== m_data) begin
         errors++;
         $display("FAIL reset_residual: got valid=%b data=%h, want valid=0 data=%h", out_valid, out_data, m_data);
      end
   endtask

   task automatic test_random();
      apply_reset();
      mode = 1'b1; dwell = 8'd2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 3));
         sel = 2'($urandom);
         in_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         out_ready = ($urandom_range(0, 3) != 0);
         rand_data();
         step();
         checks++;
         if (out_data !== m_data || out_valid !== m_valid || out_ch !== 2'(m_ch)) begin
            errors++;
            $display("FAIL random[%0d]: got %h/%b/%0d, want %h/%b/%0d", i, out_data, out_valid, out_ch, m_data, m_valid, m_ch);
         end
      end
   endtask

   initial begin
      test_reset();
      test_manual();
      test_out_of_range();
      test_scan_seq();
      test_skip_wrap();
      test_stall();
      test_reset_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
MUX_SCAN_N -- requirements
Module: mux_scan_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width per channel.
REQ-002 The block SHALL have parameter CH, default 4, legal range 2..16, giving the channel count.
REQ-003 The block SHALL have parameter SELW, default $clog2(CH), giving the channel index width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RST_N, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, CH bits: bit k high means channel k carries valid data.
REQ-008 The block SHALL have port sel, input, SELW bits: the channel index used in manual mode.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 selects manual mode, 1 selects auto-scan mode.
REQ-010 The block SHALL have port dwell, input, 8 bits: the number of accepted samples per channel in scan mode.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the registered selected data.
REQ-012 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the output.
REQ-014 The block SHALL have port out_ch, output, SELW bits: the channel index of the current out_data.

Function
REQ-015 Output register: load when (!out_valid || out_ready); otherwise hold out_data, out_valid and out_ch unchanged.
REQ-016 On load: out_data <= in_data[ptr], out_valid <= in_valid[ptr], out_ch <= ptr; latency is 1 cycle from input to output.
REQ-017 Manual mode (state MAN): ptr = sel; if sel >= CH then ptr = 0.
REQ-018 Scan mode (state SCAN): ptr is a registered index; an 8-bit counter cnt increments on each load where out_valid is loaded high.
REQ-019 Scan: when cnt reaches max(dwell,1)-1 and a load occurs, cnt <= 0 and ptr advances to the next index after ptr, in round-robin order with wrap CH-1 -> 0, whose in_valid bit is 1.
REQ-020 Scan: if no other channel is valid at the advance point, ptr stays unchanged and cnt <= 0.
REQ-021 Scan: during a stall (out_valid && !out_ready), ptr and cnt SHALL freeze.
REQ-022 FSM transitions: MAN -> SCAN when mode=1, with ptr <= clamped sel and cnt <= 0; SCAN -> MAN when mode=0, taking effect on the same cycle's selection.
REQ-023 dwell changes SHALL take effect at the next comparison; when cnt > dwell-1, the channel SHALL advance on the next load.

Reset
REQ-024 With RST_N=0 at a rising edge: out_data=0, out_valid=0, out_ch=0, ptr=0, cnt=0, state=MAN.
REQ-025 Reset mid-stall or mid-dwell SHALL discard the held data, with no residual output after RST_N rises.

Structure
REQ-026 A shared package mux_pkg SHALL hold typedef enum {MAN, SCAN} mux_state_t and constant DEF_WIDTH=16.
REQ-027 Round-robin next-valid search SHALL be one sub-module, rr_next (inputs: valid vector and current index; output: next index and a found flag).
REQ-028 Target implementation size is 120-400 lines of RTL.

Verification
REQ-029 Manual: CH=4, mode=0, sel=2, in2=16'hBEEF, valid=4'hF, out_ready=1 -> next cycle out_data=BEEF, out_ch=2, out_valid=1.
REQ-030 Out-of-range: CH=3, SELW=2, sel=3 -> out_ch=0, out_data=in0.
REQ-031 Scan: dwell=2, valid=4'b1111, ready=1 -> out_ch sequence 0,0,1,1,2,2,3,3,0.
REQ-032 Skip and wrap: dwell=1, valid=4'b1010 -> out_ch 1,3,1,3; valid=4'b0010 -> out_ch stays 1.
REQ-033 Stall: out_ready=0 for 5 cycles mid-dwell -> out_data, out_ch and cnt are frozen; sequence resumes unchanged when ready rises.
REQ-034 Reset: RST_N=0 for 1 cycle during scan with out_ready=0 -> all outputs are 0, state=MAN next cycle.
